// File: rtl/pkt_uart_rx.sv
// pkt_uart_rx: packet-framing UART receiver. Samples one serial line (8 data bits, LSB first),
// assembles NUM_BYTES bytes into pkt_data (first byte in the MS byte) and signals completion
// with a frm_rdy / clr_frm_rdy handshake. A partial packet is dropped after an inter-byte gap
// of more than IDLE_TO bit periods. Framing and overrun errors are one-cycle pulses.
// Define PKT_UART_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module pkt_uart_rx #(
    parameter int unsigned BAUD_DIV  = 868,
    parameter int unsigned NUM_BYTES = 3,
    parameter int unsigned IDLE_TO   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RX,
    input  logic                   clr_frm_rdy,
    output logic                   frm_rdy,
    output logic [8*NUM_BYTES-1:0] pkt_data,
    output logic                   frm_err,
    output logic                   ovr_err
);

    localparam int unsigned PktW     = 8 * NUM_BYTES;
    localparam int unsigned CntW     = $clog2(BAUD_DIV + 1);
    localparam int unsigned ByteCntW = $clog2(NUM_BYTES + 1);
    localparam int unsigned GapMax   = IDLE_TO * BAUD_DIV;
    localparam int unsigned GapW     = $clog2(GapMax + 2);

    localparam logic [CntW-1:0]     FullDiv  = CntW'(BAUD_DIV);
    localparam logic [CntW-1:0]     HalfDiv  = CntW'(BAUD_DIV / 2);
    localparam logic [ByteCntW-1:0] LastByte = ByteCntW'(NUM_BYTES - 1);
    localparam logic [GapW-1:0]     GapLimit = GapW'(GapMax);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StStop   = 3'd3,
        StBreak  = 3'd4
`ifdef PKT_UART_PARITY_EN
        ,
        StParity = 3'd5
`endif
    } state_e;

    state_e              state_q, state_d;
    logic                rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [2:0]          bit_idx_q, bit_idx_d;
    logic [7:0]          shift_q, shift_d;
    logic [ByteCntW-1:0] byte_cnt_q, byte_cnt_d;
    logic [PktW-1:0]     pkt_sr_q, pkt_sr_d;
    logic [GapW-1:0]     gap_q, gap_d;
    logic [PktW-1:0]     pkt_data_q, pkt_data_d;
    logic                frm_rdy_q, frm_rdy_d;
    logic                frm_err_q, frm_err_d;
    logic                ovr_err_q, ovr_err_d;
    logic                tick;
    logic                bad_frame;
`ifdef PKT_UART_PARITY_EN
    logic                par_err_q, par_err_d;
`endif

    // Two-flop synchroniser plus a delayed copy for start-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            pkt_sr_q   <= '0;
            gap_q      <= '0;
            pkt_data_q <= '0;
            frm_rdy_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            ovr_err_q  <= 1'b0;
`ifdef PKT_UART_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            byte_cnt_q <= byte_cnt_d;
            pkt_sr_q   <= pkt_sr_d;
            gap_q      <= gap_d;
            pkt_data_q <= pkt_data_d;
            frm_rdy_q  <= frm_rdy_d;
            frm_err_q  <= frm_err_d;
            ovr_err_q  <= ovr_err_d;
`ifdef PKT_UART_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    // Bit FSM, packet assembly, inter-byte timeout and handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_cnt_d = byte_cnt_q;
        pkt_sr_d   = pkt_sr_q;
        gap_d      = '0;
        pkt_data_d = pkt_data_q;
        frm_rdy_d  = frm_rdy_q & ~clr_frm_rdy;
        frm_err_d  = 1'b0;
        ovr_err_d  = 1'b0;
        tick       = (cnt_q == CntW'(1));
        bad_frame  = 1'b0;
`ifdef PKT_UART_PARITY_EN
        par_err_d  = par_err_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d = StStart;
                    cnt_d   = HalfDiv;
                end else if (byte_cnt_q != '0) begin
                    // Partial packet waiting: drop it once the gap is exceeded.
                    if (gap_q >= GapLimit) begin
                        byte_cnt_d = '0;
                    end else begin
                        gap_d = gap_q + GapW'(1);
                    end
                end
            end

            StStart: begin
                if (!tick) begin
                    cnt_d = cnt_q - CntW'(1);
                end else if (rx_sync_q) begin
                    state_d = StIdle;  // false start
                end else begin
                    state_d   = StData;
                    cnt_d     = FullDiv;
                    bit_idx_d = '0;
                end
            end

            StData: begin
                if (!tick) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    cnt_d     = FullDiv;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef PKT_UART_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end

`ifdef PKT_UART_PARITY_EN
            StParity: begin
                if (!tick) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    // Even parity: data ones plus parity bit must be even.
                    par_err_d = rx_sync_q ^ (^shift_q);
                    cnt_d     = FullDiv;
                    state_d   = StStop;
                end
            end
`endif

            StStop: begin
                if (!tick) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    bad_frame = !rx_sync_q;
`ifdef PKT_UART_PARITY_EN
                    bad_frame = bad_frame | par_err_q;
`endif
                    if (bad_frame) begin
                        frm_err_d  = 1'b1;
                        byte_cnt_d = '0;
                        state_d    = StBreak;
                    end else begin
                        state_d  = StIdle;
                        pkt_sr_d = (pkt_sr_q << 8) | PktW'(shift_q);
                        if (byte_cnt_q == LastByte) begin
                            // Completion wins over a same-cycle acknowledge.
                            pkt_data_d = pkt_sr_d;
                            frm_rdy_d  = 1'b1;
                            ovr_err_d  = frm_rdy_q & ~clr_frm_rdy;
                            byte_cnt_d = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + ByteCntW'(1);
                        end
                    end
                end
            end

            StBreak: begin
                if (rx_sync_q) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    assign frm_rdy  = frm_rdy_q;
    assign pkt_data = pkt_data_q;
    assign frm_err  = frm_err_q;
    assign ovr_err  = ovr_err_q;

endmodule

// File: tb/tb_pkt_uart_rx.sv
// Testbench for pkt_uart_rx (BAUD_DIV=16, NUM_BYTES=3, IDLE_TO=4). Packets are pushed to a
// scoreboard queue as their last byte is driven; a negedge monitor pops and compares on each
// completion. Parity scenarios run when PKT_UART_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_pkt_uart_rx;

    localparam int unsigned Baud = 16;
    localparam int unsigned Nb   = 3;
    localparam int unsigned Ito  = 4;
`ifdef PKT_UART_PARITY_EN
    localparam int unsigned StopIdx = 10;
`else
    localparam int unsigned StopIdx = 9;
`endif
    // Start-bit pin edge to frm_rdy: stop-bit midpoint + 2 sync cycles + 1 cycle.
    localparam int unsigned Lat = StopIdx * Baud + Baud / 2 + 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            rx_line = 1'b1;
    logic            clr = 1'b0;
    logic            frm_rdy;
    logic [8*Nb-1:0] pkt_data;
    logic            frm_err;
    logic            ovr_err;

    pkt_uart_rx #(
        .BAUD_DIV (Baud),
        .NUM_BYTES(Nb),
        .IDLE_TO  (Ito)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX         (rx_line),
        .clr_frm_rdy(clr),
        .frm_rdy    (frm_rdy),
        .pkt_data   (pkt_data),
        .frm_err    (frm_err),
        .ovr_err    (ovr_err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [23:0] data;
        logic        ovr;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [23:0] data;
        logic        clr_done;   // acknowledge on the completion cycle
        logic        clr_after;  // acknowledge after the packet
        logic        ovr;        // expected ovr_err pulse
        logic        rise;       // frm_rdy expected to rise (latency checked)
    } vec_t;
    vec_t vec[4];

    int unsigned last_start_cyc = 0;
    int unsigned rise_cyc = 0;
    int          err_cnt = 0;
    logic        rdy_prev = 1'b0, err_prev = 1'b0, ovr_prev = 1'b0;
    logic [23:0] data_prev = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: error pulse width, error count, and scoreboard compare on each completion.
    always @(negedge clk) begin
        if (!rst) begin
            if (frm_err) err_cnt++;
            if (frm_err && err_prev) check("frm_err_one_cycle", 32'(frm_err), 32'd0);
            if (ovr_err && ovr_prev) check("ovr_err_one_cycle", 32'(ovr_err), 32'd0);
            if ((frm_rdy && !rdy_prev) || ovr_err || (frm_rdy && pkt_data != data_prev)) begin
                if (frm_rdy && !rdy_prev) rise_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_packet", 32'(pkt_data), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_pkt_data", 32'(pkt_data), 32'(e.data));
                    check("sb_ovr_err", 32'(ovr_err), 32'(e.ovr));
                    check("sb_frm_rdy", 32'(frm_rdy), 32'd1);
                end
            end
        end
        rdy_prev  = frm_rdy;
        err_prev  = frm_err;
        ovr_prev  = ovr_err;
        data_prev = pkt_data;
    end

    task automatic drive_bit(input logic b);
        rx_line = b;
        repeat (Baud) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop, input logic par,
                             input logic clr_done);
        last_start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef PKT_UART_PARITY_EN
        drive_bit(par);
`else
        if (par) begin end
`endif
        rx_line = stop;
        if (clr_done) begin
            repeat (Baud / 2 + 2) @(negedge clk);
            clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            repeat (Baud / 2 - 3) @(negedge clk);
        end else begin
            repeat (Baud) @(negedge clk);
        end
        rx_line = 1'b1;
    endtask

    task automatic send_pkt(input logic [23:0] d, input logic clr_done, input logic ovr);
        exp_t e;
        send_byte(d[23:16], 1'b1, ^d[23:16], 1'b0);
        send_byte(d[15:8], 1'b1, ^d[15:8], 1'b0);
        e.data = d;
        e.ovr  = ovr;
        exp_q.push_back(e);
        send_byte(d[7:0], 1'b1, ^d[7:0], clr_done);
    endtask

    task automatic ack();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("frm_rdy_cleared", 32'(frm_rdy), 32'd0);
    endtask

    initial begin
        int e0;

        vec[0] = '{data: 24'hA53C0F, clr_done: 1'b0, clr_after: 1'b0, ovr: 1'b0, rise: 1'b1};
        vec[1] = '{data: 24'h112233, clr_done: 1'b0, clr_after: 1'b0, ovr: 1'b1, rise: 1'b0};
        vec[2] = '{data: 24'h445566, clr_done: 1'b1, clr_after: 1'b1, ovr: 1'b0, rise: 1'b0};
        vec[3] = '{data: 24'h778899, clr_done: 1'b0, clr_after: 1'b1, ovr: 1'b0, rise: 1'b1};

        repeat (3) @(negedge clk);
        check("reset_frm_rdy", 32'(frm_rdy), 32'd0);
        check("reset_pkt_data", 32'(pkt_data), 32'd0);
        check("reset_frm_err", 32'(frm_err), 32'd0);
        check("reset_ovr_err", 32'(ovr_err), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean packets, overrun, and acknowledge coinciding with completion.
        for (int i = 0; i < 4; i++) begin
            e0       = err_cnt;
            rise_cyc = 0;
            send_pkt(vec[i].data, vec[i].clr_done, vec[i].ovr);
            check("vec_frm_rdy", 32'(frm_rdy), 32'd1);
            check("vec_pkt_data", 32'(pkt_data), 32'(vec[i].data));
            check("vec_no_frm_err", 32'(err_cnt), 32'(e0));
            if (vec[i].rise) check("vec_latency", rise_cyc - last_start_cyc, Lat);
            if (vec[i].clr_after) ack();
        end

        // Bad stop bit on the second byte drops the partial packet.
        e0 = err_cnt;
        send_byte(8'h12, 1'b1, ^8'h12, 1'b0);
        send_byte(8'h34, 1'b0, ^8'h34, 1'b0);
        repeat (Baud) @(negedge clk);
        check("stop_err_count", 32'(err_cnt), 32'(e0 + 1));
        check("stop_err_no_rdy", 32'(frm_rdy), 32'd0);
        send_pkt(24'h010203, 1'b0, 1'b0);
        check("after_stop_err_pkt", 32'(pkt_data), 32'h010203);
        ack();

        // Inter-byte gap of 5 bit periods discards the lone first byte silently.
        e0 = err_cnt;
        send_byte(8'hAA, 1'b1, ^8'hAA, 1'b0);
        repeat (5 * Baud) @(negedge clk);
        send_pkt(24'h010203, 1'b0, 1'b0);
        check("timeout_pkt", 32'(pkt_data), 32'h010203);
        check("timeout_no_err", 32'(err_cnt), 32'(e0));
        ack();

        // Short low glitch is a false start and leaves no trace.
        e0 = err_cnt;
        rx_line = 1'b0;
        repeat (4) @(negedge clk);
        rx_line = 1'b1;
        repeat (2 * Baud) @(negedge clk);
        check("glitch_no_rdy", 32'(frm_rdy), 32'd0);
        check("glitch_no_err", 32'(err_cnt), 32'(e0));
        send_pkt(24'hC0FFEE, 1'b0, 1'b0);
        check("glitch_then_pkt", 32'(pkt_data), 32'hC0FFEE);

        // Reset in the middle of the second byte clears everything.
        send_byte(8'h5A, 1'b1, ^8'h5A, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_frm_rdy", 32'(frm_rdy), 32'd0);
        check("midrst_pkt_data", 32'(pkt_data), 32'd0);
        check("midrst_frm_err", 32'(frm_err), 32'd0);
        check("midrst_ovr_err", 32'(ovr_err), 32'd0);
        repeat (3) @(negedge clk);
        rx_line = 1'b1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rise_cyc = 0;
        send_pkt(24'h13579B, 1'b0, 1'b0);
        check("post_rst_pkt", 32'(pkt_data), 32'h13579B);
        check("post_rst_latency", rise_cyc - last_start_cyc, Lat);
        ack();

`ifdef PKT_UART_PARITY_EN
        // 0x07 has three ones, so even parity needs a 1.
        e0 = err_cnt;
        send_byte(8'h07, 1'b1, 1'b0, 1'b0);
        repeat (Baud) @(negedge clk);
        check("parity_err_count", 32'(err_cnt), 32'(e0 + 1));
        check("parity_err_no_rdy", 32'(frm_rdy), 32'd0);
        send_pkt(24'h070809, 1'b0, 1'b0);
        check("parity_ok_pkt", 32'(pkt_data), 32'h070809);
        check("parity_ok_no_err", 32'(err_cnt), 32'(e0 + 1));
        ack();
`endif

        repeat (Baud) @(negedge clk);
        check("sb_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t expected end earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pkt_uart_rx.md
Name: pkt_uart_rx

Overview:
Parametrised packet-framing UART receiver, the successor to the fixed-format command and accelerometer receivers in the CBC digital top. It samples one serial line, assembles NUM_BYTES bytes into one packet word and presents it with a frm_rdy/clr_frm_rdy handshake. Over the fixed-format receivers it adds:
- inter-byte timeout resynchronisation
- framing and overrun error reporting
- optional parity checking
One instance per serial input (controller command link, accelerometer link).

Parameters:
BAUD_DIV, 868, clk cycles per bit (800 MHz / 921,600 baud); legal range 4..65535
NUM_BYTES, 3, bytes per packet; legal range 1..8; pkt_data width = 8*NUM_BYTES
IDLE_TO, 4, inter-byte gap limit in bit periods; partial packet discarded when exceeded

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high; all state cleared while high
RX  input  1  serial line, idle high, asynchronous to clk
clr_frm_rdy  input  1  consumer acknowledge; clears frm_rdy
frm_rdy  output  1  packet available in pkt_data; held until cleared
pkt_data  output  8*NUM_BYTES  last complete packet; first received byte in the MS byte
frm_err  output  1  one-cycle pulse: bad stop bit (or parity, see option)
ovr_err  output  1  one-cycle pulse: packet completed while frm_rdy was still set

Behaviour:
- Reset values:
  - frm_rdy=0, pkt_data=0, frm_err=0, ovr_err=0
  - synchroniser flops=1, byte count=0, FSM=IDLE
- RX passes through a 2-flop synchroniser. All sampling uses the synchronised value.
- Bit FSM:
  - IDLE: a high-to-low edge on synced RX goes to START and loads the baud counter with BAUD_DIV/2.
  - START: at counter expiry (mid start bit), sample. 1 = false start, return to IDLE, no error. 0 = go to DATA with the counter reloaded to BAUD_DIV.
  - DATA: sample 8 bits, one per BAUD_DIV, LSB first. Then go to STOP (or PARITY when the option is enabled).
  - STOP: sample at mid-bit.
    - 1: byte is good and is shifted into the packet shift register.
    - 0: pulse frm_err, discard the partial packet (byte count=0), go to BREAK.
  - BREAK: wait for synced RX=1, then go to IDLE. A line held low never produces repeated errors.
- Packet assembly:
  - Byte count increments on each good byte.
  - When the count reaches NUM_BYTES: load pkt_data from the shift register, set frm_rdy, reset the count to 0.
  - frm_rdy rises one clk after the last stop-bit sample.
  - End-to-end latency from the stop-bit midpoint is 1 cycle, plus 2 cycles of synchroniser delay relative to the pin.
- Timeout:
  - While byte count is between 1 and NUM_BYTES-1 and the FSM is in IDLE, a gap counter runs.
  - If the gap exceeds IDLE_TO*BAUD_DIV cycles, the byte count clears silently (no error).
  - The gap counter resets on every start edge.
  - With NUM_BYTES=1 the timeout never applies.
- Handshake:
  - clr_frm_rdy=1 clears frm_rdy on the next edge.
  - pkt_data stays stable until the next packet completes.
- Simultaneous events:
  - Completion while frm_rdy=1 and clr_frm_rdy=0: pkt_data is overwritten, frm_rdy stays 1, ovr_err pulses.
  - Completion in the same cycle as clr_frm_rdy=1: completion wins. frm_rdy stays 1, pkt_data is updated, no ovr_err.
- Reset asserted mid-packet: all state is discarded immediately. After release, the first falling edge starts a fresh packet.
- The baud counter is $clog2(BAUD_DIV+1) bits wide and counts down to 1. There is no cumulative drift: the counter reloads at every sample.

Optional Feature:
Macro PKT_UART_PARITY_EN.
- Defined: a PARITY state follows DATA and samples an even-parity bit at mid-bit before STOP. A mismatch does all of the following:
  - pulses frm_err
  - discards the partial packet
  - goes to BREAK after the stop sample (the stop bit is still consumed)
- Not defined: 8N1 framing only; no PARITY state and no parity logic.

Test Plan:
1. BAUD_DIV=16, NUM_BYTES=3: send bytes 0xA5,0x3C,0x0F at exact bit timing -> frm_rdy rises 1 cycle after the third stop-bit midpoint; pkt_data=24'hA53C0F; frm_err=ovr_err=0.
2. frm_rdy left set, second packet 0x11,0x22,0x33 sent -> ovr_err pulses one cycle, pkt_data=24'h112233, frm_rdy stays 1. Repeat with clr_frm_rdy asserted on the completion cycle -> no ovr_err.
3. Second byte sent with stop bit=0 -> frm_err one-cycle pulse; no frm_rdy. Then a clean 0x01,0x02,0x03 -> pkt_data=24'h010203.
4. Send 0xAA, idle 5 bit periods (IDLE_TO=4), then send 0x01,0x02,0x03 -> pkt_data=24'h010203, not 24'hAA0102; no error pulses.
5. 4-cycle low glitch on RX (BAUD_DIV=16) -> false start; no state change, no outputs. rst asserted mid-second-byte -> all outputs 0; a following clean packet is received correctly.
6. With PKT_UART_PARITY_EN: byte 0x07 sent with parity bit 0 -> frm_err pulses, packet dropped. Same byte with parity bit 1 -> accepted.
